// File: rtl/mas_booth_seq_encoder.sv
// Sequential radix-4 Booth partial-product generator: one digit per cycle, lowest first, valid/ready on both sides.
// Define MAS_BOOTH_UNSIGNED_EN for unsigned operands (one extra top digit).
module mas_booth_seq_encoder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned MWIDTH = 32,
    parameter int unsigned IDXW   = $clog2(MWIDTH/2+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_mcand,
    input  logic [MWIDTH-1:0] in_mplier,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH:0]    out_pp,
    output logic              out_neg,
    output logic [IDXW-1:0]   out_idx,
    output logic              out_last
);

    localparam int unsigned PPW = WIDTH + 1;
`ifdef MAS_BOOTH_UNSIGNED_EN
    localparam int unsigned NDIG = MWIDTH/2 + 1;
    localparam int unsigned SRW  = MWIDTH + 3;
`else
    localparam int unsigned NDIG = MWIDTH/2;
    localparam int unsigned SRW  = MWIDTH + 1;
`endif
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e            state_q, state_d;
    logic [PPW-1:0]    m_q, m_d;
    logic [SRW-1:0]    sr_q, sr_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [PPW-1:0]    pp_q, pp_d;
    logic              neg_q, neg_d;
    logic              last_q, last_d;
    logic              load;
    logic [PPW-1:0]    m_in;
    logic [SRW-1:0]    sr_in;

    // Operand extension: the shift register carries the implicit B[-1]=0 in bit 0.
`ifdef MAS_BOOTH_UNSIGNED_EN
    assign m_in  = {1'b0, in_mcand};
    assign sr_in = {2'b00, in_mplier, 1'b0};
`else
    assign m_in  = {in_mcand[WIDTH-1], in_mcand};
    assign sr_in = {in_mplier, 1'b0};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            sr_q    <= '0;
            idx_q   <= '0;
            pp_q    <= '0;
            neg_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
            pp_q    <= pp_d;
            neg_q   <= neg_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
        pp_d    = pp_q;
        neg_d   = neg_q;
        last_d  = last_q;
        load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = BUSY;
                    m_d     = m_in;
                    sr_d    = sr_in;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            BUSY: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        pp_d    = '0;
                        neg_d   = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        sr_d  = sr_q >> 2;
                        idx_d = idx_q + IDXW'(1);
                        load  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Encode the digit that becomes visible next cycle.
        if (load) begin
            pp_d  = '0;
            neg_d = 1'b0;
            unique case (sr_d[2:0])
                3'b001, 3'b010: pp_d = m_d;
                3'b011:         pp_d = m_d << 1;
                3'b100: begin
                    pp_d  = m_d << 1;
                    neg_d = 1'b1;
                end
                3'b101, 3'b110: begin
                    pp_d  = m_d;
                    neg_d = 1'b1;
                end
                default:        pp_d = '0;
            endcase
            last_d = (idx_d == LAST_IDX);
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == BUSY);
    assign out_pp    = pp_q;
    assign out_neg   = neg_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;

endmodule
